// File: rtl/game_round_ctrl.sv
// ---------------------------------------------------------------------------
// game_round_ctrl
//
// Round controller for a basketball arcade game. It times a round in whole
// seconds, counts debounced baskets from the hoop switch, and latches the
// final score for the leaderboard when the round ends.
//
// Ports
//   clock       : system clock
//   reset       : synchronous, active-low reset
//   start       : high level in IDLE or OVER starts a new round
//   pause       : level-sensitive freeze of a running round
//   hoop_in     : raw asynchronous hoop switch
//   state       : 0=IDLE, 1=PLAY, 2=PAUSE, 3=OVER
//   time_left   : seconds remaining in the round
//   time_bcd    : tens:ones BCD of min(time_left, 99)
//   score       : current score (saturating)
//   score_bcd   : tens:ones BCD of min(score, 99)
//   round_done  : one-cycle pulse on the edge the round ends
//   final_score : score latched at the end of the round
//
// Build option
//   GAME_ROUND_BONUS_EN : when defined, a basket scored while
//                         time_left <= BONUS_SECS is worth 2 points.
// ---------------------------------------------------------------------------
module game_round_ctrl #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int TIME_W        = 8,
  parameter int START_SECS    = 60,
  parameter int SCORE_W       = 8,
  parameter int DEBOUNCE_CYC  = 500000,
  parameter int BONUS_SECS    = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               hoop_in,
  output logic [1:0]         state,
  output logic [TIME_W-1:0]  time_left,
  output logic [7:0]         time_bcd,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         score_bcd,
  output logic               round_done,
  output logic [SCORE_W-1:0] final_score
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
  localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
  localparam int SUM_W = SCORE_W + 1;

  state_t             state_q, state_d;
  logic               in_play;
  logic               start_round, tick, last_tick, basket;
  logic               hoop_meta, hoop_sync, hoop_deb, hoop_deb_q;
  logic [DEB_W-1:0]   deb_cnt;
  logic [PRE_W-1:0]   presc;
  logic [1:0]         score_step;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_next;

  // Clamp to 0..99 and split into two BCD digits.
  function automatic logic [7:0] to_bcd99(input logic [31:0] value);
    logic [6:0] clamped;
    logic [3:0] tens;
    clamped = (value > 32'd99) ? 7'd99 : value[6:0];
    tens    = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (clamped >= 7'(i * 10)) tens = 4'(i);
    end
    return {tens, 4'(clamped - 7'(tens) * 7'd10)};
  endfunction

  // -------------------------------------------------------------------------
  // Hoop input: 2-flop synchroniser, then a debouncer that only adopts the
  // synchronised level once it has disagreed for DEBOUNCE_CYC straight cycles.
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hoop_meta  <= 1'b0;
      hoop_sync  <= 1'b0;
      hoop_deb   <= 1'b0;
      hoop_deb_q <= 1'b0;
      deb_cnt    <= '0;
    end else begin
      hoop_meta  <= hoop_in;
      hoop_sync  <= hoop_meta;
      hoop_deb_q <= hoop_deb;
      if (hoop_sync == hoop_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        hoop_deb <= hoop_sync;
        deb_cnt  <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Debounced rising edge, seen the cycle after the debounced level flips.
  assign basket = hoop_deb & ~hoop_deb_q;

  // -------------------------------------------------------------------------
  // Round FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign start_round = ((state_q == IDLE) || (state_q == OVER)) && start;
  assign tick        = in_play && (presc == PRE_LAST);
  assign last_tick   = tick && (time_left == TIME_W'(1));

  // NOTE: combinational blocks assign a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, OVER: if (start) state_d = PLAY;
      PLAY: begin
        // The final tick wins over a simultaneous pause request.
        if (last_tick)  state_d = OVER;
        else if (pause) state_d = PAUSE;
      end
      PAUSE:      if (!pause) state_d = PLAY;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    state   = state_q;
    in_play = (state_q == PLAY);
  end

  // -------------------------------------------------------------------------
  // Basket value and saturating add
  // -------------------------------------------------------------------------
`ifdef GAME_ROUND_BONUS_EN
  assign score_step = (32'(time_left) <= 32'(BONUS_SECS)) ? 2'd2 : 2'd1;
`else
  logic bonus_unused;
  assign score_step   = 2'd1;
  assign bonus_unused = (BONUS_SECS != 0);
`endif

  assign score_sum  = {1'b0, score} + SUM_W'(score_step);
  // The step is at most 2, so any overflow shows up in the carry bit.
  assign score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  // -------------------------------------------------------------------------
  // Round datapath: prescaler, seconds, score, end-of-round latch
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      presc       <= '0;
      time_left   <= TIME_W'(START_SECS);
      score       <= '0;
      final_score <= '0;
      round_done  <= 1'b0;
    end else begin
      round_done <= 1'b0;
      if (start_round) begin
        presc     <= '0;
        time_left <= TIME_W'(START_SECS);
        score     <= '0;
      end else if (in_play) begin
        if (basket) score <= score_next;
        if (tick) begin
          presc     <= '0;
          time_left <= time_left - TIME_W'(1);
          if (last_tick) begin
            round_done  <= 1'b1;
            // Include a basket landing on the same edge as the final tick.
            final_score <= basket ? score_next : score;
          end
        end else begin
          presc <= presc + PRE_W'(1);
        end
      end
    end
  end

  assign time_bcd  = to_bcd99(32'(time_left));
  assign score_bcd = to_bcd99(32'(score));

endmodule

// File: tb/tb_game_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_round_ctrl
//
// Two instances share one stimulus stream:
//   dut_a : 4 ticks/s, 3 s round, 8-bit score  (short-round timing cases)
//   dut_b : 20 ticks/s, 12 s round, 4-bit score (saturation, long rounds)
// A behavioural model per instance, stepped on every rising edge, predicts
// all outputs; a compare process checks both instances on every falling
// edge. Directed phases add literal expectations, then a random phase runs.
// ---------------------------------------------------------------------------
module tb_game_round_ctrl;

  localparam int A_TICKS = 4;
  localparam int A_SECS  = 3;
  localparam int A_SW    = 8;
  localparam int B_TICKS = 20;
  localparam int B_SECS  = 12;
  localparam int B_SW    = 4;
  localparam int DEB     = 2;
  localparam int BONUS   = 1;
`ifdef GAME_ROUND_BONUS_EN
  localparam int EXP_FINAL_A = 3;
`else
  localparam int EXP_FINAL_A = 2;
`endif

  logic clock = 1'b0;
  logic reset, start, pause, hoop_in;

  logic [1:0]      state_a, state_b;
  logic [7:0]      time_left_a, time_left_b;
  logic [7:0]      time_bcd_a, time_bcd_b, score_bcd_a, score_bcd_b;
  logic [A_SW-1:0] score_a, final_score_a;
  logic [B_SW-1:0] score_b, final_score_b;
  logic            round_done_a, round_done_b;

  always #5 clock = ~clock;

  game_round_ctrl #(
    .TICKS_PER_SEC(A_TICKS), .TIME_W(8), .START_SECS(A_SECS), .SCORE_W(A_SW),
    .DEBOUNCE_CYC(DEB), .BONUS_SECS(BONUS)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .hoop_in(hoop_in),
    .state(state_a), .time_left(time_left_a), .time_bcd(time_bcd_a),
    .score(score_a), .score_bcd(score_bcd_a), .round_done(round_done_a),
    .final_score(final_score_a)
  );

  game_round_ctrl #(
    .TICKS_PER_SEC(B_TICKS), .TIME_W(8), .START_SECS(B_SECS), .SCORE_W(B_SW),
    .DEBOUNCE_CYC(DEB), .BONUS_SECS(BONUS)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .hoop_in(hoop_in),
    .state(state_b), .time_left(time_left_b), .time_bcd(time_bcd_b),
    .score(score_b), .score_bcd(score_bcd_b), .round_done(round_done_b),
    .final_score(final_score_b)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit [15:0] hist;      // hist[k]: hoop_in sampled k+1 edges before this one
    bit        deb;       // debounced hoop level
    bit        rose;      // debounced level rose on the previous edge
    int        state;
    int        elapsed;   // PLAY cycles since the round started
    int        time_left;
    int        score;
    int        final_s;
    bit        done;
  } model_t;

  model_t ma, mb;
  int     checks   = 0;
  int     failures = 0;
  bit     cmp_en   = 1'b0;

  function automatic model_t mstep(model_t m, bit rst_n, bit st, bit ps, bit hp,
                                   int ticks, int secs, int smax);
    model_t n;
    bit     all_diff;
    bit     basket;
    int     inc;
    n = m;
    if (!rst_n) begin
      n = '{default: 0};
      n.time_left = secs;
      return n;
    end
    basket = m.rose;
    // Synchronised value seen at this edge is hist[1]; the level is adopted
    // once the last DEB synchronised samples all disagree with it.
    all_diff = 1'b1;
    for (int k = 1; k <= DEB; k++) if (m.hist[k] == m.deb) all_diff = 1'b0;
    n.deb  = all_diff ? ~m.deb : m.deb;
    n.rose = all_diff && !m.deb;
    n.hist = {m.hist[14:0], hp};
    n.done = 1'b0;
    case (m.state)
      0, 3: if (st) begin
        n.state = 1; n.elapsed = 0; n.time_left = secs; n.score = 0;
      end
      1: begin
        if (basket) begin
          inc = 1;
`ifdef GAME_ROUND_BONUS_EN
          if (m.time_left <= BONUS) inc = 2;
`endif
          n.score = (m.score + inc > smax) ? smax : m.score + inc;
        end
        n.elapsed   = m.elapsed + 1;
        n.time_left = secs - n.elapsed / ticks;
        if (n.time_left == 0) begin
          n.state = 3; n.done = 1'b1; n.final_s = n.score;
        end else if (ps) begin
          n.state = 2;
        end
      end
      default: if (!ps) n.state = 1;
    endcase
    return n;
  endfunction

  function automatic int bcd(int v);
    if (v > 99) v = 99;
    return (v / 10) * 16 + v % 10;
  endfunction

  always @(posedge clock) begin
    ma <= mstep(ma, reset, start, pause, hoop_in, A_TICKS, A_SECS, 2**A_SW - 1);
    mb <= mstep(mb, reset, start, pause, hoop_in, B_TICKS, B_SECS, 2**B_SW - 1);
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input logic [1:0] st, input logic [31:0] tl,
                         input logic [31:0] tb, input logic [31:0] sc,
                         input logic [31:0] sb, input logic rd,
                         input logic [31:0] fs, input model_t m);
    check({tag, ".state"},       32'(st), m.state);
    check({tag, ".time_left"},   tl, m.time_left);
    check({tag, ".time_bcd"},    tb, bcd(m.time_left));
    check({tag, ".score"},       sc, m.score);
    check({tag, ".score_bcd"},   sb, bcd(m.score));
    check({tag, ".round_done"},  32'(rd), 32'(m.done));
    check({tag, ".final_score"}, fs, m.final_s);
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      compare("A", state_a, 32'(time_left_a), 32'(time_bcd_a), 32'(score_a),
              32'(score_bcd_a), round_done_a, 32'(final_score_a), ma);
      compare("B", state_b, 32'(time_left_b), 32'(time_bcd_b), 32'(score_b),
              32'(score_bcd_b), round_done_b, 32'(final_score_b), mb);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Hoop held long enough to debounce high, then low long enough to reset.
  task automatic do_basket();
    hoop_in = 1'b1;
    cyc(4);
    hoop_in = 1'b0;
    cyc(4);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    reset = 1'b0; start = 1'b0; pause = 1'b0; hoop_in = 1'b0;
    cyc(1);
    cmp_en = 1'b1;
    cyc(1);

    // Reset state, then a basic round on A.
    check("A.rst_state", 32'(state_a), 0);
    check("A.rst_time", 32'(time_left_a), 3);
    check("A.rst_score", 32'(score_a), 0);
    check("A.rst_done", 32'(round_done_a), 0);
    check("B.rst_time_bcd", 32'(time_bcd_b), 32'h12);
    reset = 1'b1;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("A.start_state", 32'(state_a), 1);
    check("A.start_time", 32'(time_left_a), 3);
    cyc(4);
    check("A.first_tick", 32'(time_left_a), 2);
    cyc(8);
    check("A.end_time", 32'(time_left_a), 0);
    check("A.end_done", 32'(round_done_a), 1);
    check("A.end_state", 32'(state_a), 3);
    check("A.end_bcd", 32'(time_bcd_a), 0);
    cyc(1);
    check("A.done_pulse", 32'(round_done_a), 0);
    check("A.over_time", 32'(time_left_a), 0);

    // Glitch rejection and hoop-to-score latency.
    start = 1'b1;
    cyc(1);
    start = 1'b0; hoop_in = 1'b1;
    cyc(1);
    hoop_in = 1'b0;
    cyc(4);
    check("A.glitch_score", 32'(score_a), 0);
    hoop_in = 1'b1;
    cyc(4);
    check("A.latency_early", 32'(score_a), 0);
    cyc(1);
    check("A.latency_score", 32'(score_a), 1);
    check("A.latency_bcd", 32'(score_bcd_a), 32'h01);
    hoop_in = 1'b0;
    cyc(6);

    // Pause freezes the round and blocks baskets.
    start = 1'b1;
    cyc(1);
    start = 1'b0; pause = 1'b1; hoop_in = 1'b1;
    cyc(5);
    hoop_in = 1'b0;
    cyc(4);
    check("A.pause_state", 32'(state_a), 2);
    check("A.pause_time", 32'(time_left_a), 3);
    check("A.pause_score", 32'(score_a), 0);
    cyc(1);
    pause = 1'b0;
    cyc(11);
    check("A.resume_state", 32'(state_a), 1);
    check("A.resume_nodone", 32'(round_done_a), 0);
    cyc(1);
    check("A.pause_end_done", 32'(round_done_a), 1);
    check("A.pause_end_state", 32'(state_a), 3);
    check("A.pause_final", 32'(final_score_a), 0);
    cyc(4);

    // Reset mid-round on B at time_left 2 with score 5.
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    repeat (5) do_basket();
    n = 0;
    while (time_left_b != 8'd2 && n < 400) begin
      cyc(1);
      n++;
    end
    check("B.reach_time2", 32'(time_left_b), 2);
    check("B.mid_score", 32'(score_b), 5);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    check("B.mid_rst_state", 32'(state_b), 0);
    check("B.mid_rst_time", 32'(time_left_b), 12);
    check("B.mid_rst_score", 32'(score_b), 0);
    check("B.mid_rst_done", 32'(round_done_b), 0);
    check("A.mid_rst_time", 32'(time_left_a), 3);

    // Score saturation on the 4-bit instance.
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("B.start_bcd", 32'(time_bcd_b), 32'h12);
    repeat (20) do_basket();
    check("B.sat_score", 32'(score_b), 15);
    check("B.sat_bcd", 32'(score_bcd_b), 32'h15);
    n = 0;
    while (state_b != 2'd3 && n < 200) begin
      cyc(1);
      n++;
    end
    check("B.sat_over", 32'(state_b), 3);
    check("B.sat_final", 32'(final_score_b), 15);
    cyc(4);

    // A: basket at time_left 2, then one on the final tick edge (time_left 1).
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    hoop_in = 1'b1;
    cyc(2);
    hoop_in = 1'b0;
    cyc(3);
    check("A.bonus_first", 32'(score_a), 1);
    check("A.bonus_first_time", 32'(time_left_a), 2);
    cyc(1);
    hoop_in = 1'b1;
    cyc(5);
    check("A.last_edge_done", 32'(round_done_a), 1);
    check("A.last_edge_final", 32'(final_score_a), EXP_FINAL_A);
    check("A.last_edge_score", 32'(score_a), EXP_FINAL_A);
    hoop_in = 1'b0;
    cyc(4);

    // Random stimulus, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      if ($urandom_range(0, 3) == 0) hoop_in = ~hoop_in;
    end
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
